line_age_tracker: RTL and testbench

- Per-set, per-way state store producing the `line_empty` / `line_age` vectors consumed by the cache's victim-selection logic.
- Tracks a valid bit and a 32-bit age per way. A touched way resets to age 0; every other valid way in that set ages by 1, so the maximum age is the least-recently-used way.
- Sits between the cache controller's hit/fill/invalidate events and the eviction chooser.
- Includes a sequential clear engine for reset and flush.

---
 rtl/line_age_tracker_pkg.sv | 27 ++
 rtl/line_age_tracker_age_set_update.sv | 78 +++++++
 rtl/line_age_tracker.sv | 159 +++++++++++++++
 tb/tb_line_age_tracker.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_age_tracker_pkg.sv
// Shared definitions for the line age tracker.
//   upd_op_e        : update opcode carried on upd_op (hit / fill / invalidate / no-op)
//   tracker_state_e : clear-engine state (CLEAR, READY)
//   AGE_W, AGE_MAX  : age width and saturation value
//   age_sat_inc     : saturating age increment
package cache_pkg;

    localparam int unsigned AGE_W = 32;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {
        UPD_HIT   = 2'b00,
        UPD_FILL  = 2'b01,
        UPD_INVAL = 2'b10,
        UPD_NOP   = 2'b11
    } upd_op_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } tracker_state_e;

    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
        return (a == AGE_MAX) ? a : a + 1'b1;
    endfunction

endpackage

// File: rtl/line_age_tracker_age_set_update.sv
// age_set_update: combinational next-state for one set's valid/age vectors.
// Ports:
//   en        : apply the operation (otherwise outputs equal inputs)
//   op        : update opcode
//   way       : target way; values >= N_WAYS make the operation a no-op
//   valid_in  : current per-way valid bits
//   age_in    : current per-way ages
//   valid_out : next per-way valid bits
//   age_out   : next per-way ages
module age_set_update
    import cache_pkg::*;
#(
    parameter int unsigned N_WAYS = 2,
    parameter int unsigned N_POW  = 4
) (
    input  logic                en,
    input  upd_op_e             op,
    input  logic [N_POW-1:0]    way,
    input  logic [N_WAYS-1:0]   valid_in,
    input  logic [AGE_W-1:0]    age_in    [N_WAYS],
    output logic [N_WAYS-1:0]   valid_out,
    output logic [AGE_W-1:0]    age_out   [N_WAYS]
);

    logic [N_WAYS-1:0] sel;
    logic              way_ok;
    logic              hit_ok;

    always_comb begin
        sel = '0;
        for (int unsigned w = 0; w < N_WAYS; w++) begin
            sel[w] = (way == N_POW'(w));
        end
        way_ok = |sel;
        hit_ok = |(sel & valid_in);

        valid_out = valid_in;
        for (int unsigned w = 0; w < N_WAYS; w++) begin
            age_out[w] = age_in[w];
        end

        if (en && way_ok) begin
            unique case (op)
                UPD_HIT: begin
                    // A hit on an invalid way leaves the whole set untouched.
                    if (hit_ok) begin
                        for (int unsigned w = 0; w < N_WAYS; w++) begin
                            if (sel[w])
                                age_out[w] = '0;
                            else if (valid_in[w])
                                age_out[w] = age_sat_inc(age_in[w]);
                        end
                    end
                end
                UPD_FILL: begin
                    for (int unsigned w = 0; w < N_WAYS; w++) begin
                        if (sel[w]) begin
                            valid_out[w] = 1'b1;
                            age_out[w]   = '0;
                        end else if (valid_in[w]) begin
                            age_out[w] = age_sat_inc(age_in[w]);
                        end
                    end
                end
                UPD_INVAL: begin
                    for (int unsigned w = 0; w < N_WAYS; w++) begin
                        if (sel[w]) begin
                            valid_out[w] = 1'b0;
                            age_out[w]   = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/line_age_tracker.sv
// line_age_tracker: per-set, per-way valid/age store feeding victim selection.
// Optional macro LINE_AGE_FORWARD_EN: a same-cycle update to the queried set
// is forwarded so the registered outputs show the post-update state.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   flush_req       : one-cycle request to invalidate every set
//   busy            : clear engine running; updates ignored
//   upd_valid/upd_set/upd_way/upd_op : update strobe and its target/opcode
//   query_set       : set presented on the outputs one cycle later
//   line_empty      : per-way empty flags of the queried set
//   line_age        : per-way ages of the queried set
module line_age_tracker
    import cache_pkg::*;
#(
    parameter int unsigned N_WAYS   = 2,
    parameter int unsigned N_POW    = 4,
    parameter int unsigned N_SETS   = 16,
    parameter int unsigned SET_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_req,
    output logic                busy,
    input  logic                upd_valid,
    input  logic [SET_BITS-1:0] upd_set,
    input  logic [N_POW-1:0]    upd_way,
    input  logic [1:0]          upd_op,
    input  logic [SET_BITS-1:0] query_set,
    output logic                line_empty [N_WAYS],
    output logic [AGE_W-1:0]    line_age   [N_WAYS]
);

    tracker_state_e      state_q, state_d;
    logic [SET_BITS-1:0] clr_idx_q, clr_idx_d;

    logic [N_WAYS-1:0]   valid_q [N_SETS];
    logic [AGE_W-1:0]    age_q   [N_SETS][N_WAYS];

    logic                upd_set_ok, upd_apply;
    logic [SET_BITS-1:0] upd_idx;
    logic [N_WAYS-1:0]   cur_valid, nxt_valid;
    logic [AGE_W-1:0]    cur_age [N_WAYS];
    logic [AGE_W-1:0]    nxt_age [N_WAYS];

    logic                q_ok;
    logic [SET_BITS-1:0] q_idx;
    logic [N_WAYS-1:0]   src_valid;
    logic [AGE_W-1:0]    src_age [N_WAYS];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == SET_BITS'(N_SETS - 1)) begin
                    state_d   = READY;
                    clr_idx_d = '0;
                end
            end
            READY: begin
                if (flush_req) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q == CLEAR);
    end

    always_comb begin
        upd_set_ok = (32'(upd_set) < N_SETS);
        upd_idx    = upd_set_ok ? upd_set : '0;
        // Flush takes priority over a same-cycle update.
        upd_apply  = (state_q == READY) && upd_valid && !flush_req && !rst && upd_set_ok;
        cur_valid  = valid_q[upd_idx];
        for (int unsigned w = 0; w < N_WAYS; w++) begin
            cur_age[w] = age_q[upd_idx][w];
        end
    end

    age_set_update #(
        .N_WAYS (N_WAYS),
        .N_POW  (N_POW)
    ) u_update (
        .en        (upd_apply),
        .op        (upd_op_e'(upd_op)),
        .way       (upd_way),
        .valid_in  (cur_valid),
        .age_in    (cur_age),
        .valid_out (nxt_valid),
        .age_out   (nxt_age)
    );

    // Array storage is initialised by the clear engine, not by reset.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            valid_q[clr_idx_q] <= '0;
            for (int unsigned w = 0; w < N_WAYS; w++) begin
                age_q[clr_idx_q][w] <= '0;
            end
        end else if (upd_apply) begin
            valid_q[upd_idx] <= nxt_valid;
            for (int unsigned w = 0; w < N_WAYS; w++) begin
                age_q[upd_idx][w] <= nxt_age[w];
            end
        end
    end

    always_comb begin
        q_ok      = (32'(query_set) < N_SETS);
        q_idx     = q_ok ? query_set : '0;
        src_valid = valid_q[q_idx];
        for (int unsigned w = 0; w < N_WAYS; w++) begin
            src_age[w] = age_q[q_idx][w];
        end
`ifdef LINE_AGE_FORWARD_EN
        if (upd_apply && (upd_set == query_set)) begin
            src_valid = nxt_valid;
            for (int unsigned w = 0; w < N_WAYS; w++) begin
                src_age[w] = nxt_age[w];
            end
        end
`endif
    end

    // flush_req is included so the first busy cycle already reads empty.
    always_ff @(posedge clk) begin
        if (rst || busy || flush_req || !q_ok) begin
            for (int unsigned w = 0; w < N_WAYS; w++) begin
                line_empty[w] <= 1'b1;
                line_age[w]   <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < N_WAYS; w++) begin
                line_empty[w] <= ~src_valid[w];
                line_age[w]   <= src_age[w];
            end
        end
    end

endmodule

// File: tb/tb_line_age_tracker.sv
module tb_line_age_tracker;

    localparam logic [1:0] OP_HIT   = 2'b00;
    localparam logic [1:0] OP_FILL  = 2'b01;
    localparam logic [1:0] OP_INVAL = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_req;
    logic        busy;
    logic        upd_valid;
    logic [3:0]  upd_set;
    logic [3:0]  upd_way;
    logic [1:0]  upd_op;
    logic [3:0]  query_set;
    logic        line_empty [2];
    logic [31:0] line_age   [2];

    int errors = 0;
    int checks = 0;

    line_age_tracker #(
        .N_WAYS   (2),
        .N_POW    (4),
        .N_SETS   (16),
        .SET_BITS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_req  (flush_req),
        .busy       (busy),
        .upd_valid  (upd_valid),
        .upd_set    (upd_set),
        .upd_way    (upd_way),
        .upd_op     (upd_op),
        .query_set  (query_set),
        .line_empty (line_empty),
        .line_age   (line_age)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [3:0] s, input logic [3:0] w, input logic [1:0] op);
        upd_valid = 1'b1;
        upd_set   = s;
        upd_way   = w;
        upd_op    = op;
        tick();
        upd_valid = 1'b0;
        upd_op    = OP_NOP;
    endtask

    task automatic do_query(input logic [3:0] s);
        query_set = s;
        tick();
    endtask

    task automatic test_reset();
        int unsigned bad_busy;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || line_empty[0] !== 1'b1 || line_empty[1] !== 1'b1 ||
            line_age[0] !== 32'd0 || line_age[1] !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b empty={%b,%b} age={%0d,%0d}, want busy=1 empty={1,1} age={0,0}",
                     busy, line_empty[0], line_empty[1], line_age[0], line_age[1]);
        end
        rst = 1'b0;
        bad_busy = 0;
        for (int n = 1; n <= 15; n++) begin
            tick();
            if (busy !== 1'b1) bad_busy++;
        end
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("FAIL clear_busy_high: busy low on %0d of 15 clear cycles, want 0", bad_busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_busy_drop: busy=%b after 16 cycles, want 0", busy);
        end
        do_query(4'd3);
        checks++;
        if (line_empty[0] !== 1'b1 || line_empty[1] !== 1'b1 ||
            line_age[0] !== 32'd0 || line_age[1] !== 32'd0) begin
            errors++;
            $display("FAIL query_set3: empty={%b,%b} age={%0d,%0d}, want empty={1,1} age={0,0}",
                     line_empty[0], line_empty[1], line_age[0], line_age[1]);
        end
    endtask

    task automatic test_fill_hit();
        do_upd(4'd2, 4'd0, OP_FILL);
        do_upd(4'd2, 4'd1, OP_FILL);
        do_query(4'd2);
        checks++;
        if (line_empty[0] !== 1'b0 || line_empty[1] !== 1'b0 ||
            line_age[0] !== 32'd1 || line_age[1] !== 32'd0) begin
            errors++;
            $display("FAIL fill_fill: empty={%b,%b} age={%0d,%0d}, want empty={0,0} age={1,0}",
                     line_empty[0], line_empty[1], line_age[0], line_age[1]);
        end
        do_upd(4'd2, 4'd0, OP_HIT);
        do_query(4'd2);
        checks++;
        if (line_age[0] !== 32'd0 || line_age[1] !== 32'd1) begin
            errors++;
            $display("FAIL hit_way0: age={%0d,%0d}, want {0,1}", line_age[0], line_age[1]);
        end
        // Out-of-range way must leave the set untouched.
        do_upd(4'd2, 4'd3, OP_FILL);
        do_query(4'd2);
        checks++;
        if (line_empty[0] !== 1'b0 || line_empty[1] !== 1'b0 ||
            line_age[0] !== 32'd0 || line_age[1] !== 32'd1) begin
            errors++;
            $display("FAIL bad_way_nop: empty={%b,%b} age={%0d,%0d}, want empty={0,0} age={0,1}",
                     line_empty[0], line_empty[1], line_age[0], line_age[1]);
        end
    endtask

    task automatic test_saturation();
        dut.age_q[2][1] = 32'hFFFF_FFFF;
        do_upd(4'd2, 4'd0, OP_FILL);
        do_upd(4'd2, 4'd0, OP_FILL);
        do_upd(4'd2, 4'd0, OP_FILL);
        do_query(4'd2);
        checks++;
        if (line_age[0] !== 32'd0 || line_age[1] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL saturate: age={%h,%h}, want {00000000,ffffffff}", line_age[0], line_age[1]);
        end
    endtask

    task automatic test_invalidate();
        do_upd(4'd2, 4'd1, OP_INVAL);
        do_query(4'd2);
        checks++;
        if (line_empty[0] !== 1'b0 || line_empty[1] !== 1'b1 || line_age[1] !== 32'd0) begin
            errors++;
            $display("FAIL inval_way1: empty={%b,%b} age1=%0d, want empty={0,1} age1=0",
                     line_empty[0], line_empty[1], line_age[1]);
        end
        do_upd(4'd2, 4'd1, OP_HIT);
        do_query(4'd2);
        checks++;
        if (line_empty[0] !== 1'b0 || line_empty[1] !== 1'b1 ||
            line_age[0] !== 32'd0 || line_age[1] !== 32'd0) begin
            errors++;
            $display("FAIL hit_invalid_nop: empty={%b,%b} age={%0d,%0d}, want empty={0,1} age={0,0}",
                     line_empty[0], line_empty[1], line_age[0], line_age[1]);
        end
        do_upd(4'd2, 4'd0, OP_HIT);
        do_query(4'd2);
        checks++;
        if (line_age[0] !== 32'd0 || line_age[1] !== 32'd0 || line_empty[1] !== 1'b1) begin
            errors++;
            $display("FAIL hit_no_age_invalid: empty1=%b age={%0d,%0d}, want empty1=1 age={0,0}",
                     line_empty[1], line_age[0], line_age[1]);
        end
    endtask

    task automatic test_flush();
        int unsigned bad_busy;
        do_upd(4'd5, 4'd1, OP_FILL);
        do_query(4'd5);
        checks++;
        if (line_empty[1] !== 1'b0) begin
            errors++;
            $display("FAIL pre_flush_fill: empty1=%b, want 0", line_empty[1]);
        end
        flush_req = 1'b1;
        upd_valid = 1'b1;
        upd_set   = 4'd5;
        upd_way   = 4'd0;
        upd_op    = OP_FILL;
        query_set = 4'd5;
        tick();
        flush_req = 1'b0;
        upd_valid = 1'b0;
        upd_op    = OP_NOP;
        checks++;
        if (busy !== 1'b1 || line_empty[0] !== 1'b1 || line_empty[1] !== 1'b1) begin
            errors++;
            $display("FAIL flush_start: busy=%b empty={%b,%b}, want busy=1 empty={1,1}",
                     busy, line_empty[0], line_empty[1]);
        end
        // Eight clear cycles, then reset mid-clear.
        for (int n = 0; n < 8; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_clear: busy=%b, want 1", busy);
        end
        bad_busy = 0;
        for (int n = 1; n <= 15; n++) begin
            tick();
            if (busy !== 1'b1) bad_busy++;
        end
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("FAIL restart_busy_high: busy low on %0d of 15 cycles, want 0", bad_busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_busy_drop: busy=%b, want 0", busy);
        end
        do_query(4'd5);
        checks++;
        if (line_empty[0] !== 1'b1 || line_empty[1] !== 1'b1 ||
            line_age[0] !== 32'd0 || line_age[1] !== 32'd0) begin
            errors++;
            $display("FAIL set5_after_flush: empty={%b,%b} age={%0d,%0d}, want empty={1,1} age={0,0}",
                     line_empty[0], line_empty[1], line_age[0], line_age[1]);
        end
        do_query(4'd2);
        checks++;
        if (line_empty[0] !== 1'b1 || line_empty[1] !== 1'b1) begin
            errors++;
            $display("FAIL set2_after_flush: empty={%b,%b}, want {1,1}", line_empty[0], line_empty[1]);
        end
    endtask

    task automatic test_forward();
        logic exp_empty0;
`ifdef LINE_AGE_FORWARD_EN
        exp_empty0 = 1'b0;
`else
        exp_empty0 = 1'b1;
`endif
        query_set = 4'd7;
        do_upd(4'd7, 4'd0, OP_FILL);
        checks++;
        if (line_empty[0] !== exp_empty0 || line_age[0] !== 32'd0) begin
            errors++;
            $display("FAIL same_cycle_query: empty0=%b age0=%0d, want empty0=%b age0=0",
                     line_empty[0], line_age[0], exp_empty0);
        end
        do_query(4'd7);
        checks++;
        if (line_empty[0] !== 1'b0 || line_empty[1] !== 1'b1 || line_age[0] !== 32'd0) begin
            errors++;
            $display("FAIL set7_after_fill: empty={%b,%b} age0=%0d, want empty={0,1} age0=0",
                     line_empty[0], line_empty[1], line_age[0]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush_req = 1'b0;
        upd_valid = 1'b0;
        upd_set   = '0;
        upd_way   = '0;
        upd_op    = OP_NOP;
        query_set = '0;
        test_reset();
        test_fill_hit();
        test_saturation();
        test_invalidate();
        test_flush();
        test_forward();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
